cdr_lock_ctrl: RTL and testbench

//  Acquisition/lock sequencer for the baud-rate PAM4 CDR loop. Watches MMPD output PHI at each

---
 rtl/cdr_pkg.sv | 44 ++++
 rtl/cdr_win_stats.sv | 68 ++++++
 rtl/cdr_lock_ctrl.sv | 229 ++++++++++++++++++++++
 tb/tb_cdr_lock_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cdr_pkg.sv
// -----------------------------------------------------------------------------
// cdr_pkg
// Shared definitions for the baud-rate PAM4 CDR loop: state encoding of the
// acquisition/lock sequencer, default PI gain shifts (also used by the loop
// filter at the CDR top level) and the |PHI| helper used for lock statistics.
// -----------------------------------------------------------------------------
package cdr_pkg;

  // Sequencer state encoding, visible on the cdr_lock_ctrl state port.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FLUSH = 2'd1;
  localparam logic [1:0] ST_ACQ   = 2'd2;
  localparam logic [1:0] ST_TRACK = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE  = ST_IDLE,
    S_FLUSH = ST_FLUSH,
    S_ACQ   = ST_ACQ,
    S_TRACK = ST_TRACK
  } cdr_state_e;

  // Default PI gain shifts: wide loop while acquiring, narrow while tracking.
  localparam logic [4:0] KP_ACQ_DEF = 5'd10;
  localparam logic [4:0] KI_ACQ_DEF = 5'd16;
  localparam logic [4:0] KP_TRK_DEF = 5'd12;
  localparam logic [4:0] KI_TRK_DEF = 5'd18;

  // kp and ki live in one register so the filter never sees a mixed pair.
  typedef struct packed {
    logic [4:0] kp;
    logic [4:0] ki;
  } gain_pair_t;

  // Magnitude of a signed 16-bit sample, computed in 17 bits and saturated
  // back to 16 bits so -32768 maps to 32767 instead of wrapping.
  function automatic logic [15:0] abs_sat16(input logic [15:0] x);
    logic [16:0] ext;
    logic [16:0] mag;
    ext = {x[15], x};
    mag = x[15] ? (~ext + 17'd1) : ext;
    return (mag[16] || mag[15]) ? 16'h7FFF : mag[15:0];
  endfunction

endpackage

// File: rtl/cdr_win_stats.sv
// -----------------------------------------------------------------------------
// cdr_win_stats
// Windowed |PHI| statistics for the CDR lock sequencer. Every sample_en strobe
// is one symbol; a symbol is "good" when its saturated |PHI| is below LOCK_TH.
// Symbols are grouped in windows of 2**WIN_LOG2 strobes.
//
// Ports
//   clk        in   system clock
//   rst_n      in   asynchronous active-low reset
//   clr        in   synchronous clear of the window position and good count
//   sample_en  in   symbol strobe
//   phi        in   signed MMPD output, valid with sample_en
//   win_done   out  high on the strobe that completes a window (combinational)
//   good_cnt   out  good symbols in the current window including this strobe
// -----------------------------------------------------------------------------
module cdr_win_stats
  import cdr_pkg::*;
#(
  parameter int WIN_LOG2 = 6,
  parameter int LOCK_TH  = 1024
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clr,
  input  logic                sample_en,
  input  logic [15:0]         phi,
  output logic                win_done,
  output logic [WIN_LOG2:0]   good_cnt
);

  localparam logic [15:0]         TH_C    = 16'(LOCK_TH);
  localparam logic [WIN_LOG2-1:0] POS_END = {WIN_LOG2{1'b1}};

  logic [WIN_LOG2-1:0] pos_q, pos_d;
  logic [WIN_LOG2:0]   good_q, good_d;
  logic [15:0]         phi_mag;
  logic                good_bit;

  assign phi_mag  = abs_sat16(phi);
  assign good_bit = sample_en && (phi_mag < TH_C);

  always_comb begin
    // The closing strobe's own verdict is part of the window result, so the
    // count handed out is the stored count plus the current symbol.
    good_cnt = good_q + {{WIN_LOG2{1'b0}}, good_bit};
    win_done = sample_en && (pos_q == POS_END);
    pos_d    = pos_q;
    good_d   = good_q;
    if (clr) begin
      pos_d  = '0;
      good_d = '0;
    end else if (sample_en) begin
      pos_d  = pos_q + WIN_LOG2'(1);
      good_d = win_done ? '0 : good_cnt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos_q  <= '0;
      good_q <= '0;
    end else begin
      pos_q  <= pos_d;
      good_q <= good_d;
    end
  end

endmodule

// File: rtl/cdr_lock_ctrl.sv
// -----------------------------------------------------------------------------
// cdr_lock_ctrl
// Acquisition/lock sequencer for the baud-rate PAM4 CDR loop. Flushes the PI
// filter, acquires with wide gains, declares lock from windowed |PHI|
// statistics, tracks with narrow gains and re-acquires on loss of lock or
// acquisition timeout. All outputs are registered.
//
// Ports
//   clk         in   system clock
//   rst_n       in   asynchronous active-low reset
//   enable      in   run request; low forces IDLE on the next cycle
//   sample_en   in   CDR symbol strobe
//   phi         in   signed MMPD output, valid with sample_en
//   loop_rst    out  hold the PI filter integrator/output at zero
//   kp_shift    out  proportional gain shift to the filter
//   ki_shift    out  integral gain shift to the filter
//   state       out  0 IDLE, 1 FLUSH, 2 ACQ, 3 TRACK
//   locked      out  high exactly while in TRACK
//   lock_lost   out  one-cycle pulse on TRACK->ACQ
//   acq_tmo     out  one-cycle pulse on ACQ->FLUSH timeout
//   relock_cnt  out  saturating count of lock_lost events, cleared by reset
// -----------------------------------------------------------------------------
module cdr_lock_ctrl
  import cdr_pkg::*;
#(
  parameter int         WIN_LOG2  = 6,
  parameter int         LOCK_TH   = 1024,
  parameter int         GOOD_MIN  = 56,
  parameter int         BAD_MAX   = 32,
  parameter int         LOCK_WINS = 4,
  parameter int         LOSS_WINS = 2,
  parameter int         ACQ_TMO   = 64,
  parameter int         FLUSH_SYM = 16,
  parameter logic [4:0] KP_ACQ    = KP_ACQ_DEF,
  parameter logic [4:0] KI_ACQ    = KI_ACQ_DEF,
  parameter logic [4:0] KP_TRK    = KP_TRK_DEF,
  parameter logic [4:0] KI_TRK    = KI_TRK_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        sample_en,
  input  logic [15:0] phi,
  output logic        loop_rst,
  output logic [4:0]  kp_shift,
  output logic [4:0]  ki_shift,
  output logic [1:0]  state,
  output logic        locked,
  output logic        lock_lost,
  output logic        acq_tmo,
  output logic [7:0]  relock_cnt
);

  localparam int CW   = WIN_LOG2 + 1;
  localparam int GR_W = $clog2(LOCK_WINS + 1);
  localparam int BR_W = $clog2(LOSS_WINS + 1);
  localparam int WC_W = $clog2(ACQ_TMO + 1);
  localparam int FL_W = $clog2(FLUSH_SYM + 1);

  localparam logic [CW-1:0]   GOOD_MIN_C  = CW'(GOOD_MIN);
  localparam logic [CW-1:0]   BAD_MAX_C   = CW'(BAD_MAX);
  localparam logic [GR_W-1:0] LOCK_WINS_C = GR_W'(LOCK_WINS);
  localparam logic [BR_W-1:0] LOSS_WINS_C = BR_W'(LOSS_WINS);
  localparam logic [WC_W-1:0] ACQ_TMO_C   = WC_W'(ACQ_TMO);
  localparam logic [FL_W-1:0] FLUSH_END_C = FL_W'(FLUSH_SYM - 1);

  cdr_state_e        state_q, state_d;
  logic [FL_W-1:0]   flush_q, flush_d;
  logic [GR_W-1:0]   good_run_q, good_run_d;
  logic [BR_W-1:0]   bad_run_q, bad_run_d;
  logic [WC_W-1:0]   win_cnt_q, win_cnt_d;
  logic [7:0]        relock_q, relock_d;
  gain_pair_t        gain_q, gain_d;
  logic              loop_rst_q, loop_rst_d;
  logic              locked_q, locked_d;
  logic              lock_lost_q, lock_lost_d;
  logic              acq_tmo_q, acq_tmo_d;

  logic              stats_clr;
  logic              win_done;
  logic [CW-1:0]     good_cnt;

  // Window statistics only run in ACQ/TRACK; any other state (and a dropped
  // enable) keeps them cleared so a new acquisition starts on a fresh window.
  assign stats_clr = !enable || (state_q == S_IDLE) || (state_q == S_FLUSH);

  cdr_win_stats #(
    .WIN_LOG2 (WIN_LOG2),
    .LOCK_TH  (LOCK_TH)
  ) u_win_stats (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (stats_clr),
    .sample_en (sample_en),
    .phi       (phi),
    .win_done  (win_done),
    .good_cnt  (good_cnt)
  );

  always_comb begin
    state_d     = state_q;
    flush_d     = flush_q;
    good_run_d  = good_run_q;
    bad_run_d   = bad_run_q;
    win_cnt_d   = win_cnt_q;
    relock_d    = relock_q;
    lock_lost_d = 1'b0;
    acq_tmo_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        flush_d    = '0;
        good_run_d = '0;
        bad_run_d  = '0;
        win_cnt_d  = '0;
        if (enable) begin
          state_d = S_FLUSH;
        end
      end

      S_FLUSH: begin
        if (sample_en) begin
          if (flush_q == FLUSH_END_C) begin
            flush_d = '0;
            state_d = S_ACQ;
          end else begin
            flush_d = flush_q + FL_W'(1);
          end
        end
      end

      S_ACQ: begin
        if (win_done) begin
          good_run_d = (good_cnt >= GOOD_MIN_C) ? (good_run_q + GR_W'(1)) : '0;
          win_cnt_d  = win_cnt_q + WC_W'(1);
          // Lock is checked first so a window that both completes the lock
          // run and exhausts the timeout budget still ends in TRACK.
          if (good_run_d == LOCK_WINS_C) begin
            state_d    = S_TRACK;
            good_run_d = '0;
            win_cnt_d  = '0;
            bad_run_d  = '0;
          end else if (win_cnt_d == ACQ_TMO_C) begin
            state_d    = S_FLUSH;
            acq_tmo_d  = 1'b1;
            good_run_d = '0;
            win_cnt_d  = '0;
          end
        end
      end

      S_TRACK: begin
        if (win_done) begin
          bad_run_d = (good_cnt < BAD_MAX_C) ? (bad_run_q + BR_W'(1)) : '0;
          if (bad_run_d == LOSS_WINS_C) begin
            // Re-acquire without flushing: the filter keeps its state.
            state_d     = S_ACQ;
            bad_run_d   = '0;
            lock_lost_d = 1'b1;
            if (relock_q != 8'hFF) begin
              relock_d = relock_q + 8'd1;
            end
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // A dropped enable wins over whatever the window logic decided this
    // cycle, including its pulses and the relock count.
    if (!enable) begin
      state_d     = S_IDLE;
      flush_d     = '0;
      good_run_d  = '0;
      bad_run_d   = '0;
      win_cnt_d   = '0;
      relock_d    = relock_q;
      lock_lost_d = 1'b0;
      acq_tmo_d   = 1'b0;
    end

    // Outputs are decoded from the next state so they change on the same
    // edge as the state itself.
    loop_rst_d = (state_d == S_IDLE) || (state_d == S_FLUSH);
    locked_d   = (state_d == S_TRACK);
    gain_d     = locked_d ? '{kp: KP_TRK, ki: KI_TRK} : '{kp: KP_ACQ, ki: KI_ACQ};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      flush_q     <= '0;
      good_run_q  <= '0;
      bad_run_q   <= '0;
      win_cnt_q   <= '0;
      relock_q    <= '0;
      gain_q      <= '{kp: KP_ACQ, ki: KI_ACQ};
      loop_rst_q  <= 1'b1;
      locked_q    <= 1'b0;
      lock_lost_q <= 1'b0;
      acq_tmo_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      flush_q     <= flush_d;
      good_run_q  <= good_run_d;
      bad_run_q   <= bad_run_d;
      win_cnt_q   <= win_cnt_d;
      relock_q    <= relock_d;
      gain_q      <= gain_d;
      loop_rst_q  <= loop_rst_d;
      locked_q    <= locked_d;
      lock_lost_q <= lock_lost_d;
      acq_tmo_q   <= acq_tmo_d;
    end
  end

  assign state      = state_q;
  assign loop_rst   = loop_rst_q;
  assign kp_shift   = gain_q.kp;
  assign ki_shift   = gain_q.ki;
  assign locked     = locked_q;
  assign lock_lost  = lock_lost_q;
  assign acq_tmo    = acq_tmo_q;
  assign relock_cnt = relock_q;

endmodule

// File: tb/tb_cdr_lock_ctrl.sv
// -----------------------------------------------------------------------------
// tb_cdr_lock_ctrl
// Self-checking bench for cdr_lock_ctrl: directed sequences, a threshold
// vector table and randomized traffic, all compared every cycle against a
// window-level reference model.
// -----------------------------------------------------------------------------
module tb_cdr_lock_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        enable = 1'b0;
  logic        sample_en = 1'b0;
  logic [15:0] phi = 16'd0;
  logic        loop_rst;
  logic [4:0]  kp_shift;
  logic [4:0]  ki_shift;
  logic [1:0]  state;
  logic        locked;
  logic        lock_lost;
  logic        acq_tmo;
  logic [7:0]  relock_cnt;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: states as integers, the current window as a list of
  // per-symbol good flags that is summed when it reaches 64 entries.
  int   m_state;
  int   m_flush;
  int   m_good_run;
  int   m_bad_run;
  int   m_win_cnt;
  int   m_relock;
  logic m_lost;
  logic m_tmo;
  int   m_win[$];

  localparam logic [15:0] P5000N = 16'hEC78;  // -5000

  typedef struct {
    logic [15:0] phi;
    logic [1:0]  st;
    logic        lk;
    logic [4:0]  kp;
  } thr_vec_t;

  thr_vec_t vecs[9];

  always #5 clk = ~clk;

  cdr_lock_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .sample_en  (sample_en),
    .phi        (phi),
    .loop_rst   (loop_rst),
    .kp_shift   (kp_shift),
    .ki_shift   (ki_shift),
    .state      (state),
    .locked     (locked),
    .lock_lost  (lock_lost),
    .acq_tmo    (acq_tmo),
    .relock_cnt (relock_cnt)
  );

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
    $fatal(1, "watchdog");
  end

  function automatic int phi_good(input logic [15:0] p);
    int v;
    int a;
    v = int'($signed(p));
    a = (v < 0) ? -v : v;
    if (a > 32767) a = 32767;
    return (a < 1024) ? 1 : 0;
  endfunction

  task automatic model_reset();
    m_state = 0; m_flush = 0; m_good_run = 0; m_bad_run = 0;
    m_win_cnt = 0; m_relock = 0; m_lost = 1'b0; m_tmo = 1'b0;
    m_win.delete();
  endtask

  task automatic model_step(input logic e, input logic s, input logic [15:0] p);
    int g;
    m_lost = 1'b0;
    m_tmo  = 1'b0;
    if (!e) begin
      m_state = 0; m_flush = 0; m_good_run = 0; m_bad_run = 0; m_win_cnt = 0;
      m_win.delete();
    end else if (m_state == 0) begin
      m_state = 1;
      m_flush = 0;
    end else if (m_state == 1) begin
      if (s) begin
        m_flush++;
        if (m_flush == 16) begin
          m_flush = 0;
          m_state = 2;
          m_win.delete();
        end
      end
    end else if (s) begin
      m_win.push_back(phi_good(p));
      if (m_win.size() == 64) begin
        g = 0;
        foreach (m_win[i]) g += m_win[i];
        m_win.delete();
        if (m_state == 2) begin
          m_win_cnt++;
          m_good_run = (g >= 56) ? m_good_run + 1 : 0;
          if (m_good_run == 4) begin
            m_state = 3; m_good_run = 0; m_win_cnt = 0; m_bad_run = 0;
          end else if (m_win_cnt == 64) begin
            m_state = 1; m_tmo = 1'b1; m_good_run = 0; m_win_cnt = 0; m_flush = 0;
          end
        end else begin
          m_bad_run = (g < 32) ? m_bad_run + 1 : 0;
          if (m_bad_run == 2) begin
            m_state = 2; m_bad_run = 0; m_lost = 1'b1;
            if (m_relock < 255) m_relock++;
          end
        end
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model(input string name);
    logic [23:0] act_v;
    logic [23:0] exp_v;
    logic        trk;
    trk   = (m_state == 3);
    act_v = {state, loop_rst, kp_shift, ki_shift, locked, lock_lost, acq_tmo, relock_cnt};
    exp_v = {2'(m_state), (m_state < 2), trk ? 5'd12 : 5'd10, trk ? 5'd18 : 5'd16,
             trk, m_lost, m_tmo, 8'(m_relock)};
    chk(name, 32'(act_v), 32'(exp_v));
  endtask

  // One clock: drive inputs, let the edge happen, advance the model, compare.
  task automatic cyc(input logic e, input logic s, input logic [15:0] p);
    enable    = e;
    sample_en = s;
    phi       = p;
    @(posedge clk);
    model_step(e, s, p);
    #1;
    check_model("cycle");
  endtask

  // Asynchronous reset applied between clock edges and checked before any edge.
  task automatic apply_reset();
    enable    = 1'b0;
    sample_en = 1'b0;
    phi       = 16'd0;
    #1 rst_n = 1'b0;
    #1;
    model_reset();
    check_model("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic logic [15:0] gen_phi(input int pct_bad);
    int          mag;
    logic [15:0] r;
    if (int'($urandom_range(0, 99)) < pct_bad) mag = int'($urandom_range(1024, 32768));
    else mag = int'($urandom_range(0, 1023));
    r = 16'(mag);
    return ($urandom_range(0, 1) != 0) ? (~r + 16'd1) : r;
  endfunction

  // Enable, flush and acquire on a clean signal; lock must land on strobe 272.
  task automatic run_clean_lock(input string tag);
    cyc(1'b1, 1'b0, 16'($urandom));
    chk("lock_flush_entry", 32'(state), 32'd1);
    for (int n = 1; n <= 272; n++) begin
      cyc(1'b1, 1'b1, 16'd0);
      if (n == 15)  chk("lock_still_flush", 32'({state, loop_rst}), 32'({2'd1, 1'b1}));
      if (n == 16)  chk("lock_acq_entry", 32'({state, loop_rst}), 32'({2'd2, 1'b0}));
      if (n == 271) chk("lock_not_early", 32'(state), 32'd2);
      if (n == 272) begin
        chk("lock_state", 32'(state), 32'd3);
        chk("lock_gains", 32'({kp_shift, ki_shift}), 32'({5'd12, 5'd18}));
        chk("lock_locked", 32'(locked), 32'd1);
      end
      cyc(1'b1, 1'b0, 16'($urandom));
    end
    $display("[%s] lock sequence: state=%0d kp=%0d ki=%0d locked=%0d", tag, state, kp_shift, ki_shift, locked);
  endtask

  int pct_tab[7] = '{0, 60, 0, 15, 60, 0, 3};
  int len_tab[7] = '{3000, 6500, 2000, 3000, 3000, 2000, 3000};

  initial begin
    vecs[0] = '{16'd1023, 2'd3, 1'b1, 5'd12};
    vecs[1] = '{16'hFC01, 2'd3, 1'b1, 5'd12};  // -1023
    vecs[2] = '{16'd1024, 2'd2, 1'b0, 5'd10};
    vecs[3] = '{16'hFC00, 2'd2, 1'b0, 5'd10};  // -1024
    vecs[4] = '{16'h8000, 2'd2, 1'b0, 5'd10};  // -32768 saturates to 32767
    vecs[5] = '{16'h7FFF, 2'd2, 1'b0, 5'd10};
    vecs[6] = '{16'h0000, 2'd3, 1'b1, 5'd12};
    vecs[7] = '{16'hFFFF, 2'd3, 1'b1, 5'd12};  // -1
    vecs[8] = '{16'h8001, 2'd2, 1'b0, 5'd10};  // -32767

    // Reset and idle
    apply_reset();
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_outputs", 32'({loop_rst, kp_shift, ki_shift, locked, lock_lost, acq_tmo}),
        32'({1'b1, 5'd10, 5'd16, 1'b0, 1'b0, 1'b0}));
    chk("rst_relock", 32'(relock_cnt), 32'd0);
    for (int n = 0; n < 100; n++) begin
      cyc(1'b0, 1'b1, 16'($urandom));
      cyc(1'b0, 1'b0, 16'($urandom));
    end
    chk("idle_state", 32'(state), 32'd0);
    chk("idle_outputs", 32'({loop_rst, kp_shift, ki_shift}), 32'({1'b1, 5'd10, 5'd16}));
    $display("[idle] 100 strobes with enable low: state=%0d loop_rst=%0d", state, loop_rst);

    // Clean lock
    run_clean_lock("clean");

    // Loss of lock: two windows of |phi|=5000
    for (int n = 1; n <= 128; n++) begin
      cyc(1'b1, 1'b1, n[0] ? 16'd5000 : P5000N);
      if (n == 127) chk("loss_not_early", 32'({state, lock_lost}), 32'({2'd3, 1'b0}));
      if (n == 128) begin
        chk("loss_pulse", 32'(lock_lost), 32'd1);
        chk("loss_state", 32'({state, locked, loop_rst}), 32'({2'd2, 1'b0, 1'b0}));
        chk("loss_relock", 32'(relock_cnt), 32'd1);
        chk("loss_gains", 32'({kp_shift, ki_shift}), 32'({5'd10, 5'd16}));
      end
      cyc(1'b1, 1'b0, 16'($urandom));
    end
    chk("loss_pulse_end", 32'(lock_lost), 32'd0);
    $display("[loss] state=%0d relock_cnt=%0d", state, relock_cnt);

    // Acquisition timeout: 64 bad windows, strobing every cycle
    for (int n = 1; n <= 4096; n++) begin
      cyc(1'b1, 1'b1, 16'd4000);
      if (n == 4095) chk("tmo_not_early", 32'({state, acq_tmo}), 32'({2'd2, 1'b0}));
      if (n == 4096) begin
        chk("tmo_pulse", 32'(acq_tmo), 32'd1);
        chk("tmo_state", 32'({state, loop_rst}), 32'({2'd1, 1'b1}));
      end
    end
    cyc(1'b1, 1'b0, 16'd0);
    chk("tmo_pulse_end", 32'({acq_tmo, state}), 32'({1'b0, 2'd1}));
    $display("[timeout] state=%0d loop_rst=%0d relock_cnt=%0d", state, loop_rst, relock_cnt);

    // Async reset mid-window, then a full re-lock from scratch
    for (int n = 0; n < 116; n++) cyc(1'b1, 1'b1, 16'd0);
    chk("mid_acq", 32'(state), 32'd2);
    apply_reset();
    chk("mid_rst_relock", 32'({state, relock_cnt, loop_rst}), 32'({2'd0, 8'd0, 1'b1}));
    run_clean_lock("after_reset");

    // Enable dropped on the strobe that would complete the 4th good window
    apply_reset();
    cyc(1'b1, 1'b0, 16'd0);
    for (int n = 0; n < 16 + 255; n++) cyc(1'b1, 1'b1, 16'd0);
    chk("ovr_pre", 32'(state), 32'd2);
    cyc(1'b0, 1'b1, 16'd0);
    chk("ovr_idle", 32'({state, locked, lock_lost, loop_rst}), 32'({2'd0, 1'b0, 1'b0, 1'b1}));
    chk("ovr_gains", 32'({kp_shift, ki_shift}), 32'({5'd10, 5'd16}));
    cyc(1'b1, 1'b0, 16'd0);
    chk("ovr_restart", 32'(state), 32'd1);
    $display("[override] state=%0d locked=%0d", state, locked);

    // Threshold table: 3 clean windows, then 55 zeros plus 9 copies of phi
    for (int v = 0; v < 9; v++) begin
      apply_reset();
      cyc(1'b1, 1'b0, 16'd0);
      for (int n = 0; n < 16 + 192 + 55; n++) cyc(1'b1, 1'b1, 16'd0);
      for (int n = 0; n < 9; n++) cyc(1'b1, 1'b1, vecs[v].phi);
      chk("thr_state", 32'(state), 32'(vecs[v].st));
      chk("thr_locked", 32'(locked), 32'(vecs[v].lk));
      chk("thr_kp", 32'(kp_shift), 32'(vecs[v].kp));
      $display("[thr %0d] phi=%04h state=%0d locked=%0d", v, vecs[v].phi, state, locked);
    end

    // Randomized traffic against the model
    apply_reset();
    for (int seg = 0; seg < 7; seg++) begin
      if (seg == 5) apply_reset();
      for (int n = 0; n < len_tab[seg]; n++) begin
        cyc($urandom_range(0, 1499) != 0, $urandom_range(0, 3) != 0, gen_phi(pct_tab[seg]));
      end
      $display("[rand seg %0d] bad%%=%0d state=%0d relock_cnt=%0d", seg, pct_tab[seg], state, relock_cnt);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
